// File: rtl/hpdmc_wrseq_if.sv
// -----------------------------------------------------------------------------
// hpdmc_wrseq_if
//
// Bundle of the signals that pass between the write-burst sequencer and its
// neighbours: the command FSM, the write-data FIFO and the DDR output
// register pairs for DQ, DM and DQS.
//
// Signals:
//   write        command FSM -> seq  write command issued to SDRAM this cycle
//   write_ready  seq -> command FSM  a write in this cycle is legal
//   wr_err       seq -> command FSM  sticky illegal-write flag
//   read_safe    seq -> command FSM  a read command is legal this cycle
//   wdata        FIFO -> seq         write data, [DQ_WIDTH-1:0] = first half-beat
//   wmask        FIFO -> seq         byte masks, same split as wdata
//   wdata_ack    seq -> FIFO         wdata/wmask consumed at this clock edge
//   dq_d0/d1     seq -> DQ ODDR      D0/D1 of the DQ output registers
//   dm_d0/d1     seq -> DM ODDR      D0/D1 of the DM output registers
//   dqs_d0/d1    seq -> DQS ODDR     D0/D1 of the DQS output registers
//   dq_oe        seq -> pads         DQ/DM tristate enable
//   dqs_oe       seq -> pads         DQS tristate enable
//
// Modports:
//   master  the controller side that issues writes and supplies data
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface hpdmc_wrseq_if #(
  parameter int DQ_WIDTH = 16
);
  localparam int DM_WIDTH = DQ_WIDTH / 8;

  // Command side
  logic                    write;
  logic                    write_ready;
  logic                    wr_err;
  logic                    read_safe;

  // Write-data FIFO side
  logic [2*DQ_WIDTH-1:0]   wdata;
  logic [2*DM_WIDTH-1:0]   wmask;
  logic                    wdata_ack;

  // DDR output register side
  logic [DQ_WIDTH-1:0]     dq_d0;
  logic [DQ_WIDTH-1:0]     dq_d1;
  logic [DM_WIDTH-1:0]     dm_d0;
  logic [DM_WIDTH-1:0]     dm_d1;
  logic [DM_WIDTH-1:0]     dqs_d0;
  logic [DM_WIDTH-1:0]     dqs_d1;
  logic                    dq_oe;
  logic                    dqs_oe;

  modport master (
    output write, wdata, wmask,
    input  write_ready, wr_err, read_safe, wdata_ack,
           dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe, dqs_oe
  );

  modport slave (
    input  write, wdata, wmask,
    output write_ready, wr_err, read_safe, wdata_ack,
           dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe, dqs_oe
  );

endinterface : hpdmc_wrseq_if

// File: rtl/hpdmc_wrseq.sv
// -----------------------------------------------------------------------------
// hpdmc_wrseq
//
// Write-burst sequencer for the HPDMC DDR datapath. A write command accepted
// in cycle T produces a DQS preamble in T+WL, BURST_CYCLES data beats in
// T+WL+1 .. T+WL+BURST_CYCLES and a postamble right after the last beat. The
// sequencer pulls data from the write FIFO one cycle ahead of each beat,
// spaces consecutive writes so their bursts cannot overlap and holds off
// reads until the write-to-read turnaround (TWTR) has elapsed.
//
// Parameters:
//   DQ_WIDTH      SDRAM DQ pin count, multiple of 8
//   BURST_CYCLES  sys_clk cycles per burst, 1..4
//   WL            cycles from command to DQS preamble, 1..4
//   TWTR          cycles read_safe stays low after the last postamble, 1..15
//
// Ports:
//   sys_clk    sole clock, rising edge
//   sdram_rst  synchronous, active-high reset
//   bus        hpdmc_wrseq_if.slave: command handshake, write-data FIFO
//              handshake and the D0/D1/OE drives of the DDR output registers
//
// Every output comes straight from a flop; the flops are loaded from the
// next-state view of the internal state so that no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module hpdmc_wrseq #(
  parameter int DQ_WIDTH     = 16,
  parameter int BURST_CYCLES = 2,
  parameter int WL           = 1,
  parameter int TWTR         = 2
) (
  input  logic            sys_clk,
  input  logic            sdram_rst,
  hpdmc_wrseq_if.slave    bus
);

  localparam int DM_WIDTH = DQ_WIDTH / 8;

  // Token window: bit k set means cycle (now + k - 1) is a beat cycle. Bit 0
  // remembers the previous cycle so the postamble can be recognised; the
  // furthest slot ever written is WL+BURST_CYCLES.
  localparam int DEPTH = WL + BURST_CYCLES + 2;
  localparam int SP_W  = 3;
  localparam int TW_W  = 4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]    tok_q,  tok_d;
  logic [SP_W-1:0]     sp_q,   sp_d;    // cycles left in the write spacing
  logic [TW_W-1:0]     twtr_q, twtr_d;  // cycles left in the turnaround

  // Registered outputs
  logic                write_ready_q;
  logic                wr_err_q;
  logic                read_safe_q;
  logic                wdata_ack_q;
  logic                dq_oe_q;
  logic                dqs_oe_q;
  logic [DQ_WIDTH-1:0] dq_d0_q, dq_d1_q;
  logic [DM_WIDTH-1:0] dm_d0_q, dm_d1_q;
  logic [DM_WIDTH-1:0] dqs_d0_q, dqs_d1_q;

  // Next-cycle decodes
  logic accept;
  logic illegal;
  logic post_only;
  logic beat_d;
  logic ack_d;
  logic dqs_oe_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would make synthesis infer a latch.
  always_comb begin
    accept    = bus.write & write_ready_q;
    illegal   = bus.write & ~write_ready_q;

    // Advance time by one cycle, then drop in the new burst's beats.
    tok_d     = {1'b0, tok_q[DEPTH-1:1]};
    if (accept) begin
      for (int i = WL + 1; i <= WL + BURST_CYCLES; i++) begin
        tok_d[i] = 1'b1;
      end
    end

    // Spacing: after an accepted write, block the next BURST_CYCLES-1 cycles.
    sp_d = sp_q;
    if (accept) begin
      sp_d = SP_W'(BURST_CYCLES - 1);
    end else if (sp_q != '0) begin
      sp_d = sp_q - SP_W'(1);
    end

    // The current cycle is a pure postamble when the previous cycle carried a
    // beat and neither this cycle nor the next one does. A postamble that is
    // also a gap preamble does not restart the turnaround.
    post_only = tok_q[0] & ~tok_q[1] & ~tok_q[2];

    twtr_d = twtr_q;
    if (post_only) begin
      twtr_d = TW_W'(TWTR);
    end else if (twtr_q != '0) begin
      twtr_d = twtr_q - TW_W'(1);
    end

    // Decodes for the cycle that starts at the coming edge.
    beat_d   = tok_d[1];
    ack_d    = tok_d[2];
    dqs_oe_d = tok_d[0] | tok_d[1] | tok_d[2];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      tok_q         <= '0;
      sp_q          <= '0;
      twtr_q        <= '0;
      write_ready_q <= 1'b1;
      wr_err_q      <= 1'b0;
      read_safe_q   <= 1'b1;
      wdata_ack_q   <= 1'b0;
      dq_oe_q       <= 1'b0;
      dqs_oe_q      <= 1'b0;
      // NOTE: the data-path registers are reset too, because they drive the
      // output pins directly and must read 0 in the cycle after reset.
      dq_d0_q       <= '0;
      dq_d1_q       <= '0;
      dm_d0_q       <= '0;
      dm_d1_q       <= '0;
      dqs_d0_q      <= '0;
      dqs_d1_q      <= '0;
    end else begin
      tok_q         <= tok_d;
      sp_q          <= sp_d;
      twtr_q        <= twtr_d;
      write_ready_q <= (sp_d == '0);
      wr_err_q      <= wr_err_q | illegal;
      // Reads wait for every scheduled or in-flight burst and the turnaround.
      read_safe_q   <= (tok_d == '0) && (twtr_d == '0);
      wdata_ack_q   <= ack_d;
      dq_oe_q       <= beat_d;
      dqs_oe_q      <= dqs_oe_d;
      // The FIFO word acknowledged this cycle is the one launched next cycle.
      dq_d0_q       <= beat_d ? bus.wdata[DQ_WIDTH-1:0]            : '0;
      dq_d1_q       <= beat_d ? bus.wdata[2*DQ_WIDTH-1:DQ_WIDTH]   : '0;
      dm_d0_q       <= beat_d ? bus.wmask[DM_WIDTH-1:0]            : '0;
      dm_d1_q       <= beat_d ? bus.wmask[2*DM_WIDTH-1:DM_WIDTH]   : '0;
      dqs_d0_q      <= beat_d ? '1 : '0;
      dqs_d1_q      <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.write_ready = write_ready_q;
  assign bus.wr_err      = wr_err_q;
  assign bus.read_safe   = read_safe_q;
  assign bus.wdata_ack   = wdata_ack_q;
  assign bus.dq_oe       = dq_oe_q;
  assign bus.dqs_oe      = dqs_oe_q;
  assign bus.dq_d0       = dq_d0_q;
  assign bus.dq_d1       = dq_d1_q;
  assign bus.dm_d0       = dm_d0_q;
  assign bus.dm_d1       = dm_d1_q;
  assign bus.dqs_d0      = dqs_d0_q;
  assign bus.dqs_d1      = dqs_d1_q;

endmodule : hpdmc_wrseq

// File: tb/tb_hpdmc_wrseq.sv
// -----------------------------------------------------------------------------
// tb_hpdmc_wrseq
//
// Drives hpdmc_wrseq through the directed write scenarios and a long random
// run. A cycle-indexed reference model derives every output from the recorded
// input history: which writes were accepted, where their beats fall, and the
// turnaround windows that follow each pure postamble.
// -----------------------------------------------------------------------------
module tb_hpdmc_wrseq;

  localparam int DQ   = 16;
  localparam int DM   = DQ / 8;
  localparam int BC   = 2;
  localparam int WL   = 1;
  localparam int TWTR = 2;
  localparam int MAXC = 4096;

  typedef struct packed {
    logic          write_ready;
    logic          wr_err;
    logic          wdata_ack;
    logic          dq_oe;
    logic          dqs_oe;
    logic          read_safe;
    logic [DQ-1:0] dq_d0;
    logic [DQ-1:0] dq_d1;
    logic [DM-1:0] dm_d0;
    logic [DM-1:0] dm_d1;
    logic [DM-1:0] dqs_d0;
    logic [DM-1:0] dqs_d1;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hpdmc_wrseq_if #(.DQ_WIDTH(DQ)) bus ();

  hpdmc_wrseq #(
    .DQ_WIDTH    (DQ),
    .BURST_CYCLES(BC),
    .WL          (WL),
    .TWTR        (TWTR)
  ) dut (
    .sys_clk  (clk),
    .sdram_rst(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Recorded input history and model bookkeeping, indexed by cycle.
  bit              wr_in  [MAXC];
  bit              rst_in [MAXC];
  bit              acc    [MAXC];
  bit              rdy    [MAXC];
  logic [2*DQ-1:0] wd_in  [MAXC];
  logic [2*DM-1:0] wm_in  [MAXC];

  int   cyc    = -1;
  int   checks = 0;
  int   passed = 0;
  obs_t got, exp;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int last_rst(int c);
    for (int i = c - 1; i >= 0; i--) if (rst_in[i]) return i;
    return -1;
  endfunction

  // Cycle x carries a beat of some write accepted after reset r.
  function automatic bit beat_at(int x, int r);
    for (int t = x - WL - BC; t <= x - WL - 1; t++)
      if (t > r && t >= 0 && acc[t]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t model(int c);
    obs_t e;
    int   r;
    bit   b, bn, bp;
    e  = '0;
    r  = last_rst(c);
    b  = beat_at(c, r);
    bn = beat_at(c + 1, r);
    bp = beat_at(c - 1, r);
    e.dq_oe     = b;
    e.wdata_ack = bn;
    e.dqs_oe    = b | bn | bp;
    if (b) begin
      e.dq_d0  = wd_in[c-1][DQ-1:0];
      e.dq_d1  = wd_in[c-1][2*DQ-1:DQ];
      e.dm_d0  = wm_in[c-1][DM-1:0];
      e.dm_d1  = wm_in[c-1][2*DM-1:DM];
      e.dqs_d0 = '1;
    end
    e.write_ready = 1'b1;
    for (int t = c - BC + 1; t <= c - 1; t++)
      if (t > r && t >= 0 && acc[t]) e.write_ready = 1'b0;
    e.wr_err = 1'b0;
    for (int t = (r + 1 > 0 ? r + 1 : 0); t <= c - 1; t++)
      if (wr_in[t] && !rdy[t]) e.wr_err = 1'b1;
    // Reads blocked from T+1 through the last beat, and from each pure
    // postamble p through p+TWTR.
    e.read_safe = 1'b1;
    for (int t = c - 40; t <= c - 1; t++)
      if (t > r && t >= 0 && acc[t] && c <= t + WL + BC) e.read_safe = 1'b0;
    for (int p = c - TWTR; p <= c; p++)
      if (p > r && beat_at(p - 1, r) && !beat_at(p, r) && !beat_at(p + 1, r))
        e.read_safe = 1'b0;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // One clock cycle: drive inputs, sample outputs mid-cycle, update model.
  // ---------------------------------------------------------------------------
  task automatic tick(input logic w, input logic r,
                      input logic [2*DQ-1:0] wd, input logic [2*DM-1:0] wm);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    bus.write  = w;
    rst        = r;
    bus.wdata  = wd;
    bus.wmask  = wm;
    wr_in[cyc]  = w;
    rst_in[cyc] = r;
    wd_in[cyc]  = wd;
    wm_in[cyc]  = wm;
    @(negedge clk);
    got.write_ready = bus.write_ready;
    got.wr_err      = bus.wr_err;
    got.wdata_ack   = bus.wdata_ack;
    got.dq_oe       = bus.dq_oe;
    got.dqs_oe      = bus.dqs_oe;
    got.read_safe   = bus.read_safe;
    got.dq_d0       = bus.dq_d0;
    got.dq_d1       = bus.dq_d1;
    got.dm_d0       = bus.dm_d0;
    got.dm_d1       = bus.dm_d1;
    got.dqs_d0      = bus.dqs_d0;
    got.dqs_d1      = bus.dqs_d1;
    exp = model(cyc);
    rdy[cyc] = exp.write_ready;
    acc[cyc] = w && !r && exp.write_ready;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    obs_t rv;
    rv = '0;
    rv.write_ready = 1'b1;
    rv.read_safe   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, k < 3, $urandom, 4'($urandom));
      if (k >= 1) begin
        checks++;
        if (got !== rv) $display("FAIL reset c=%0d got=%h want=%h", cyc, got, rv);
        else passed++;
      end
    end
  endtask

  task automatic test_single();
    logic [2*DQ-1:0] a, b, wd;
    a = 32'hA5A5_1234;
    b = 32'h5A5A_CDEF;
    for (int k = -2; k < 12; k++) begin
      wd = (k == 1) ? a : (k == 2) ? b : $urandom;
      tick(k == 0, 1'b0, wd, 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL single c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k == 1) begin
        checks++;
        if (got.wdata_ack !== 1'b1 || got.write_ready !== 1'b0 || got.dqs_oe !== 1'b1)
          $display("FAIL single_ack ack=%b rdy=%b dqs_oe=%b want 1/0/1",
                   got.wdata_ack, got.write_ready, got.dqs_oe);
        else passed++;
      end
      if (k == 2 || k == 3) begin
        checks++;
        if ({got.dq_d1, got.dq_d0} !== (k == 2 ? a : b) || got.dqs_d0 !== 2'h3 ||
            got.dq_oe !== 1'b1)
          $display("FAIL single_beat k=%0d dq=%h dqs_d0=%h want dq=%h dqs_d0=3",
                   k, {got.dq_d1, got.dq_d0}, got.dqs_d0, (k == 2 ? a : b));
        else passed++;
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (got.read_safe !== (k == 7))
          $display("FAIL single_read_safe k=%0d got=%b want=%b", k, got.read_safe, k == 7);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks, dqs_hi;
    acks = 0;
    dqs_hi = 0;
    for (int k = -2; k < 12; k++) begin
      tick(k == 0 || k == 2, 1'b0, $urandom, 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL back_to_back c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k >= 0) acks += int'(got.wdata_ack);
      if (k >= 1 && k <= 6) dqs_hi += int'(got.dqs_oe);
      if (k == 8 || k == 9) begin
        checks++;
        if (got.read_safe !== (k == 9))
          $display("FAIL b2b_read_safe k=%0d got=%b want=%b", k, got.read_safe, k == 9);
        else passed++;
      end
    end
    checks++;
    if (acks != 4 || dqs_hi != 6)
      $display("FAIL b2b_counts acks=%0d dqs_hi=%0d want 4/6", acks, dqs_hi);
    else passed++;
  endtask

  task automatic test_gap();
    for (int k = -2; k < 12; k++) begin
      tick(k == 0 || k == 3, 1'b0, $urandom, 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL gap c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k == 4) begin
        checks++;
        if (got.dqs_oe !== 1'b1 || got.dq_oe !== 1'b0 || got.dqs_d0 !== 2'h0 ||
            got.dqs_d1 !== 2'h0)
          $display("FAIL gap_cycle dqs_oe=%b dq_oe=%b dqs=%h/%h want 1/0/0/0",
                   got.dqs_oe, got.dq_oe, got.dqs_d0, got.dqs_d1);
        else passed++;
      end
    end
  endtask

  task automatic test_illegal();
    int acks;
    acks = 0;
    for (int k = -2; k < 12; k++) begin
      tick(k == 0 || k == 1, 1'b0, $urandom, 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL illegal c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k >= 0) acks += int'(got.wdata_ack);
      if (k == 1 || k == 2) begin
        checks++;
        if (got.wr_err !== (k == 2))
          $display("FAIL illegal_err k=%0d got=%b want=%b", k, got.wr_err, k == 2);
        else passed++;
      end
    end
    checks++;
    if (acks != 2) $display("FAIL illegal_acks got=%0d want=2", acks);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int late_acks;
    late_acks = 0;
    for (int k = -2; k < 10; k++) begin
      tick(k == 0 || k == 2, k == 2, $urandom, 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL reset_mid c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k >= 3) late_acks += int'(got.wdata_ack);
      if (k == 3) begin
        checks++;
        if (got.dq_oe !== 1'b0 || got.dqs_oe !== 1'b0 || got.read_safe !== 1'b1 ||
            got.write_ready !== 1'b1 || got.wr_err !== 1'b0)
          $display("FAIL reset_mid_state dq_oe=%b dqs_oe=%b rs=%b rdy=%b err=%b want 0/0/1/1/0",
                   got.dq_oe, got.dqs_oe, got.read_safe, got.write_ready, got.wr_err);
        else passed++;
      end
    end
    checks++;
    if (late_acks != 0) $display("FAIL reset_mid_acks got=%0d want=0", late_acks);
    else passed++;
  endtask

  task automatic test_mask();
    for (int k = -2; k < 8; k++) begin
      tick(k == 0, 1'b0, $urandom, (k == 1) ? 4'hC : 4'($urandom));
      checks++;
      if (got !== exp) $display("FAIL mask c=%0d got=%h want=%h", cyc, got, exp);
      else passed++;
      if (k == 2) begin
        checks++;
        if (got.dm_d0 !== 2'h0 || got.dm_d1 !== 2'h3)
          $display("FAIL mask_dm dm_d0=%h dm_d1=%h want 0/3", got.dm_d0, got.dm_d1);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 1500; k++) begin
      tick($urandom_range(0, 99) < 45, $urandom_range(0, 199) == 0,
           $urandom, 4'($urandom));
      checks++;
      if (got !== exp) begin
        bad++;
        if (bad <= 10) $display("FAIL random c=%0d got=%h want=%h", cyc, got, exp);
      end else passed++;
    end
  endtask

  initial begin
    bus.write = 1'b0;
    bus.wdata = '0;
    bus.wmask = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_illegal();
    test_reset_mid();
    test_mask();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_hpdmc_wrseq

// File: doc/hpdmc_wrseq.md
# hpdmc_wrseq

Write-burst sequencer for the HPDMC DDR datapath. It accepts write command strobes from the command FSM, schedules write-data beats at a fixed write latency, and drives the D0/D1 inputs and output enables of the DQ, DM and DQS DDR output register pairs. It also enforces write-to-write spacing and write-to-read turnaround towards the command FSM. It sits between the command FSM and write-data FIFO on one side and the DDR output registers on the other.

## Interface
- DQ_WIDTH, 16: SDRAM DQ pin count; multiple of 8.
- BURST_CYCLES, 2: sys_clk cycles per burst (BL4 = 2); range 1..4.
- WL, 1: sys_clk cycles from command cycle to DQS preamble cycle; range 1..4.
- TWTR, 2: cycles read_safe stays low after the last postamble; range 1..15.

- sys_clk  in  1  sole clock, rising edge.
- sdram_rst  in  1  synchronous, active-high reset.
- write  in  1  write command issued to SDRAM this cycle.
- write_ready  out  1  a write in this cycle is legal.
- wr_err  out  1  sticky; set when write arrives while write_ready=0.
- wdata  in  2*DQ_WIDTH  write data; [DQ_WIDTH-1:0] = first half-beat.
- wmask  in  2*DQ_WIDTH/8  byte masks, same split as wdata.
- wdata_ack  out  1  wdata/wmask consumed at this clock edge.
- dq_d0, dq_d1  out  DQ_WIDTH  to DQ output register D0/D1.
- dm_d0, dm_d1  out  DQ_WIDTH/8  to DM output register D0/D1.
- dqs_d0, dqs_d1  out  DQ_WIDTH/8  to DQS output register D0/D1.
- dq_oe  out  1  DQ/DM tristate enable.
- dqs_oe  out  1  DQS tristate enable.
- read_safe  out  1  read command is legal this cycle.

## Operation
- A write accepted in cycle T schedules a preamble at T+WL and beats i=0..BURST_CYCLES-1 in cycles T+WL+1+i.
- Implementation uses a beat-token shift register of depth WL+BURST_CYCLES+2, a spacing counter and a TWTR counter. No other state.
- Cycle c is a beat cycle if any accepted write schedules a beat in c. In a beat cycle:
  - dq_oe=1.
  - dq_d0/dq_d1 and dm_d0/dm_d1 carry the wdata/wmask halves captured at the end of cycle c-1.
  - dqs_d0 is all ones and dqs_d1 all zeros.
- dqs_oe=1 in cycle c if c is a beat cycle, or c+1 is a beat cycle (preamble), or c-1 is a beat cycle (postamble). Outside beat cycles, dqs_d0, dqs_d1, dq_d*, dm_d* are 0.
- wdata_ack=1 in cycle c if and only if c+1 is a beat cycle. Exactly BURST_CYCLES acks are issued per accepted write.
- Spacing: write_ready=0 in cycles T+1..T+BURST_CYCLES-1 after an accepted write, and 1 otherwise. A write at exactly T+BURST_CYCLES produces gapless beats, and dqs_oe stays high across the junction.
- A write with write_ready=0 is ignored: no beats, no acks. It sets wr_err, which stays set until reset.
- Turnaround:
  - read_safe drops in cycle T+1.
  - The TWTR counter reloads at each postamble cycle that is not also a beat cycle or preamble.
  - read_safe returns high TWTR cycles after the last such postamble, i.e. it is 1 from postamble+TWTR+1.
  - A write accepted during the countdown drops read_safe again at its own T+1.
- One-cycle gap between bursts: the gap cycle is both postamble and preamble. dqs_oe=1, dq_oe=0 and DQS is 0/0 in that cycle.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- In the cycle after sdram_rst is high, all outputs are 0 except write_ready=1 and read_safe=1. wr_err clears.
- Reset mid-burst: scheduled tokens are discarded, no further wdata_ack is issued, and dq_oe/dqs_oe are 0 from the next cycle.
- A write in the same cycle as sdram_rst is dropped.
- Latency from command to first beat is WL+1 cycles, and from command to first wdata_ack is WL cycles.

## Test plan
Defaults used throughout: DQ_WIDTH=16, BURST_CYCLES=2, WL=1, TWTR=2.
- Single write at cycle 10, wdata=A then B:
  - wdata_ack=1 in cycles 11-12; dqs_oe=1 in cycles 11-14; dq_oe=1 in cycles 12-13 with dq_d0/dq_d1 = A, then B.
  - dqs_d0=0x3 in cycles 12-13; write_ready=0 in cycle 11 only; read_safe=0 in cycles 11-16 and 1 at cycle 17.
- Gapless writes at cycles 10 and 12: dq_oe=1 in cycles 12-15, dqs_oe=1 in cycles 11-16 with no drop, four acks in cycles 11-14, read_safe=1 at cycle 19.
- Writes at cycles 10 and 13: beats in cycles 12, 13, 15 and 16. In cycle 14, dqs_oe=1, dq_oe=0 and DQS is 0/0.
- Write at cycle 10, then write at cycle 11: the second write is ignored, wr_err=1 from cycle 12, and only two acks are issued.
- Write at cycle 10 with sdram_rst high in cycle 12: dq_oe=dqs_oe=0 from cycle 13, and no ack after cycle 12. read_safe=1 and write_ready=1 in cycle 13.
- Masked write with wmask=0x0C: dm_d0=0x0 and dm_d1=0x3 in the first beat cycle.
